// File: rtl/bcd_seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_seg_pkg                                                  |
// | Description : Shared definitions for the BCD seven-segment scanner:        |
// |               segment bit order and the segment patterns for 0..9, the     |
// |               invalid-digit 'E' and blank.                                 |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package bcd_seg_pkg;

  // Segment bit positions inside a seg_t: {g,f,e,d,c,b,a}, active-high.
  typedef enum logic [2:0] {
    SEG_A = 3'd0,
    SEG_B = 3'd1,
    SEG_C = 3'd2,
    SEG_D = 3'd3,
    SEG_E = 3'd4,
    SEG_F = 3'd5,
    SEG_G = 3'd6
  } seg_bit_e;

  typedef logic [6:0] seg_t;

  localparam seg_t c_seg_0     = 7'b0111111;
  localparam seg_t c_seg_1     = 7'b0000110;
  localparam seg_t c_seg_2     = 7'b1011011;
  localparam seg_t c_seg_3     = 7'b1001111;
  localparam seg_t c_seg_4     = 7'b1100110;
  localparam seg_t c_seg_5     = 7'b1101101;
  localparam seg_t c_seg_6     = 7'b1111101;
  localparam seg_t c_seg_7     = 7'b0000111;
  localparam seg_t c_seg_8     = 7'b1111111;
  localparam seg_t c_seg_9     = 7'b1101111;
  localparam seg_t c_seg_err   = 7'b1111001;  // 'E' for digit values 10..15
  localparam seg_t c_seg_blank = 7'b0000000;

endpackage : bcd_seg_pkg
`default_nettype wire

// File: rtl/bcd_seg_dec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_seg_dec                                                  |
// | Description : Combinational 4-bit to seven-segment decoder. Values 0..9    |
// |               map to the usual glyphs, 10..15 map to 'E', and blank_i      |
// |               forces all segments off.                                     |
// | Ports       : digit_i [3:0] - digit value to decode                        |
// |               blank_i       - force blank pattern                          |
// |               seg_o   [6:0] - segments {g,f,e,d,c,b,a}, active-high        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bcd_seg_dec
  import bcd_seg_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = c_seg_err;
    if (blank_i) begin
      seg_o = c_seg_blank;
    end else begin
      case (digit_i)
        4'd0:    seg_o = c_seg_0;
        4'd1:    seg_o = c_seg_1;
        4'd2:    seg_o = c_seg_2;
        4'd3:    seg_o = c_seg_3;
        4'd4:    seg_o = c_seg_4;
        4'd5:    seg_o = c_seg_5;
        4'd6:    seg_o = c_seg_6;
        4'd7:    seg_o = c_seg_7;
        4'd8:    seg_o = c_seg_8;
        4'd9:    seg_o = c_seg_9;
        default: seg_o = c_seg_err;
      endcase
    end
  end

endmodule : bcd_seg_dec
`default_nettype wire

// File: rtl/bcd_seg_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_seg_scan                                                 |
// | Description : Multiplexed seven-segment scanner for N_DIGITS packed BCD    |
// |               digits. A prescaler sets the dwell time per digit; new data  |
// |               is double-buffered and only swapped in at the frame          |
// |               boundary so a frame never mixes old and new digits.          |
// | Config      : define BCD_SEG_LEADING_ZERO_BLANK_EN to blank leading zeros  |
// |               (digit 0 is never blanked).                                  |
// | Ports       : clk        - clock, rising edge                              |
// |               rst        - synchronous active-high reset                   |
// |               load       - strobe capturing bcd_in into pending buffer     |
// |               bcd_in     - packed BCD, digit 0 in bits [3:0]               |
// |               seg  [6:0] - registered segments {g,f,e,d,c,b,a}             |
// |               an   [N-1:0] - registered one-hot digit enable               |
// |               frame_tick - one-cycle pulse as the display buffer updates   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bcd_seg_scan
  import bcd_seg_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_tick
);

  localparam int c_idx_w = $clog2(N_DIGITS);
  localparam int c_psc_w = $clog2(SCAN_DIV);
  localparam int c_bcd_w = 4 * N_DIGITS;

  logic [c_psc_w-1:0]  psc_q, psc_d;
  logic [c_idx_w-1:0]  idx_q, idx_d;
  logic [c_bcd_w-1:0]  pend_q, pend_d;
  logic                pend_vld_q, pend_vld_d;
  logic [c_bcd_w-1:0]  disp_q, disp_d;
  seg_t                seg_q;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                frame_tick_q;

  logic                slot_end;
  logic                frame_end;
  logic [3:0]          digit_sel;
  logic                blank_sel;
  seg_t                dec_seg;

  assign slot_end  = (psc_q == c_psc_w'(SCAN_DIV - 1));
  assign frame_end = slot_end && (idx_q == c_idx_w'(N_DIGITS - 1));

  // Next-state logic for scan counters and the double buffer.
  always_comb begin
    psc_d      = slot_end ? '0 : psc_q + 1'b1;
    idx_d      = idx_q;
    disp_d     = disp_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (slot_end) begin
      idx_d = frame_end ? '0 : idx_q + 1'b1;
    end
    if (frame_end && pend_vld_q) begin
      disp_d = pend_q;
    end
    // A load on the wrap cycle lands in pending after the copy above, so it
    // waits for the following frame boundary.
    if (load) begin
      pend_d     = bcd_in;
      pend_vld_d = 1'b1;
    end else if (frame_end) begin
      pend_vld_d = 1'b0;
    end
  end

  // Digit mux and one-hot enable for the current scan slot.
  always_comb begin
    digit_sel = 4'd0;
    an_d      = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == c_idx_w'(k)) begin
        digit_sel = disp_q[4*k +: 4];
        an_d[k]   = 1'b1;
      end
    end
  end

`ifdef BCD_SEG_LEADING_ZERO_BLANK_EN
  // Digit k>0 is a leading zero when it and every digit above it are zero.
  always_comb begin
    blank_sel = 1'b0;
    for (int k = 1; k < N_DIGITS; k++) begin
      if (idx_q == c_idx_w'(k)) begin
        blank_sel = ((disp_q >> (4 * k)) == '0);
      end
    end
  end
`else
  assign blank_sel = 1'b0;
`endif

  bcd_seg_dec u_dec (
    .digit_i (digit_sel),
    .blank_i (blank_sel),
    .seg_o   (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q        <= '0;
      idx_q        <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      disp_q       <= '0;
      seg_q        <= c_seg_blank;
      an_q         <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      psc_q        <= psc_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      disp_q       <= disp_d;
      seg_q        <= dec_seg;
      an_q         <= an_d;
      frame_tick_q <= frame_end;
    end
  end

  // Outputs are forced dark while reset is held, including the first cycle
  // before the registers have seen a reset edge.
  assign seg        = rst ? c_seg_blank : seg_q;
  assign an         = rst ? '0 : an_q;
  assign frame_tick = frame_tick_q & ~rst;

endmodule : bcd_seg_scan
`default_nettype wire
